// File: rtl/sevenseg_pkg.sv
// Shared 7-segment display types, constants and the hex-to-segment table.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package sevenseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern; zero latency.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode display scanner with frame-aligned double buffering and blink.
// Registered outputs track the scan state with no extra lag; an never has more than one bit low.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int SHOW_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int TMAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = $clog2(N_DIGITS);
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  scan_state_t   state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          frame_end;

  logic [4*N_DIGITS-1:0] stg_value, act_value;
  logic [N_DIGITS-1:0]   stg_dp, act_dp;
  logic [N_DIGITS-1:0]   stg_en, act_en;
  logic [N_DIGITS-1:0]   stg_blink, act_blink;

  logic [FW-1:0] frame_cnt;
  logic          blink_off;

  logic [3:0]          nibble;
  logic [6:0]          seg_dec;
  logic                lit;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      timer <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    idx_nxt   = idx;
    frame_end = 1'b0;
    case (state)
      BLANK: begin
        if (timer == BLANK_LAST) begin
          state_nxt = SHOW;
          timer_nxt = '0;
        end
      end
      SHOW: begin
        if (timer == SHOW_LAST) begin
          state_nxt = BLANK;
          timer_nxt = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          frame_end = (idx == IDX_LAST);
        end
      end
      default: begin
        state_nxt = BLANK;
        timer_nxt = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Active copy only moves at a frame boundary; a coincident load lands in staging for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_value <= '0;
      stg_dp    <= '0;
      stg_en    <= '0;
      stg_blink <= '0;
      act_value <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      act_blink <= '0;
    end else begin
      if (load) begin
        stg_value <= value;
        stg_dp    <= dp_in;
        stg_en    <= digit_en;
        stg_blink <= blink_en;
      end
      if (frame_end) begin
        act_value <= stg_value;
        act_dp    <= stg_dp;
        act_en    <= stg_en;
        act_blink <= stg_blink;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Output terms are built from the next scan position so the registers line up with the state.
  assign nibble = act_value[{idx_nxt, 2'b00} +: 4];
  assign lit    = act_en[idx_nxt] && !(act_blink[idx_nxt] && blink_off);

  sevenseg_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_comb begin
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    an_nxt  = AN_OFF[N_DIGITS-1:0];
    if (state_nxt == SHOW && lit) begin
      an_nxt[idx_nxt] = 1'b0;
      seg_nxt         = seg_dec;
      dp_nxt          = ~act_dp[idx_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      an         <= AN_OFF[N_DIGITS-1:0];
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      an         <= an_nxt;
      frame_done <= frame_end;
    end
  end

endmodule
